// File: rtl/sram_burst_arbiter_if.sv
// Requester and SRAM-side signal bundle for the burst-locking SRAM arbiter.
interface sram_burst_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            req_we;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*LEN_WIDTH-1:0]  req_len;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_PORTS-1:0]            wbeat;
  logic [NUM_PORTS-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]           rsp_rdata;
  logic                            mem_cs;
  logic                            mem_we;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            busy;
  logic [ID_WIDTH-1:0]             owner;

  // Environment side: requesters plus the SRAM read-data return
  modport master (
    output req_valid, req_we, req_addr, req_len, wdata, mem_rdata,
    input  req_ready, wbeat, rsp_valid, rsp_rdata,
           mem_cs, mem_we, mem_addr, mem_wdata, busy, owner
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_we, req_addr, req_len, wdata, mem_rdata,
    output req_ready, wbeat, rsp_valid, rsp_rdata,
           mem_cs, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/sram_burst_arbiter.sv
// Round-robin, burst-locking arbiter sharing one single-port SRAM among
// NUM_PORTS requesters. Ownership is held for a whole burst; the round-robin
// pointer only advances when a command is accepted.
module sram_burst_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic clk,
  input  logic rst,
  sram_burst_arbiter_if.slave bus
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  we_q, we_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic                  rsp_pending_q;
  logic [ID_WIDTH-1:0]   rsp_id_q;

  logic                  win_found_c;
  logic [ID_WIDTH-1:0]   win_idx_c;
  logic [ID_WIDTH-1:0]   cand_c;
  logic                  busy_c;
  logic                  wr_beat_c;

  // Winner = first valid requester at or after the round-robin pointer
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int k = 0; k < int'(NUM_PORTS); k++) begin
      cand_c = ID_WIDTH'((32'(rr_ptr_q) + 32'(k)) % NUM_PORTS);
      if (!win_found_c && bus.req_valid[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  // Next-state: latch the winning command in IDLE, count beats in BURST
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    base_d   = base_q;
    len_d    = len_q;
    we_d     = we_q;
    beat_d   = beat_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_c) begin
          state_d  = S_BURST;
          owner_d  = win_idx_c;
          base_d   = bus.req_addr[int'(win_idx_c)*int'(ADDR_WIDTH) +: ADDR_WIDTH];
          len_d    = bus.req_len[int'(win_idx_c)*int'(LEN_WIDTH) +: LEN_WIDTH];
          we_d     = bus.req_we[win_idx_c];
          beat_d   = '0;
          rr_ptr_d = (win_idx_c == ID_WIDTH'(NUM_PORTS - 1)) ? '0
                                                            : win_idx_c + ID_WIDTH'(1);
        end
      end
      S_BURST: begin
        beat_d = beat_q + LEN_WIDTH'(1);
        if (beat_q == len_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs; reset forces everything quiet, including a burst in flight
  always_comb begin
    busy_c        = (state_q == S_BURST) && !rst;
    wr_beat_c     = busy_c && we_q;
    bus.busy      = busy_c;
    bus.owner     = owner_q;
    bus.req_ready = (state_q == S_IDLE && win_found_c && !rst)
                    ? (NUM_PORTS'(1) << win_idx_c) : '0;
    bus.mem_cs    = busy_c;
    bus.mem_we    = wr_beat_c;
    bus.mem_addr  = busy_c ? (base_q + ADDR_WIDTH'(beat_q)) : '0;
    bus.mem_wdata = wr_beat_c
                    ? bus.wdata[int'(owner_q)*int'(DATA_WIDTH) +: DATA_WIDTH] : '0;
    bus.wbeat     = wr_beat_c ? (NUM_PORTS'(1) << owner_q) : '0;
    bus.rsp_valid = (rsp_pending_q && !rst) ? (NUM_PORTS'(1) << rsp_id_q) : '0;
    bus.rsp_rdata = bus.mem_rdata;
  end

  // State registers; read-return tag follows the beat by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      base_q        <= '0;
      len_q         <= '0;
      we_q          <= 1'b0;
      beat_q        <= '0;
      rsp_pending_q <= 1'b0;
      rsp_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      base_q        <= base_d;
      len_q         <= len_d;
      we_q          <= we_d;
      beat_q        <= beat_d;
      rsp_pending_q <= busy_c && !we_q;
      rsp_id_q      <= owner_q;
    end
  end

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// Scoreboard bench for sram_burst_arbiter: stimulus pushes expected grants,
// beats and read responses (with their cycle numbers); a negedge monitor pops
// and compares whenever the DUT presents one.
module tb_sram_burst_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_burst_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                          .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

  sram_burst_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .LEN_WIDTH(LW), .ID_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model, one-cycle read latency
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int cyc; int port; } grant_t;
  typedef struct { int cyc; int port; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } beat_t;
  typedef struct { int cyc; int port; logic [DW-1:0] data; } rsp_t;
  grant_t gq[$];
  beat_t  bq[$];
  rsp_t   rq[$];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {16'hD5A0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int k);
    while (cyc < k) next_cyc();
  endtask

  task automatic set_cmd(input int p, input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    bus.req_we[p]             = we;
    bus.req_addr[p*AW +: AW]  = a;
    bus.req_len[p*LW +: LW]   = l;
    bus.req_valid[p]          = 1'b1;
  endtask

  // Expected grant at t, beats t+1.., read data t+2..; data is d0+i per beat
  task automatic exp_burst(input int t, input int port, input logic we,
                           input logic [AW-1:0] addr, input int len, input logic [DW-1:0] d0);
    grant_t g;
    beat_t  b;
    rsp_t   r;
    g.cyc = t; g.port = port;
    gq.push_back(g);
    for (int i = 0; i <= len; i++) begin
      b.cyc = t + 1 + i; b.port = port; b.we = we;
      b.addr = addr + AW'(i);
      b.wdata = we ? d0 + DW'(i) : '0;
      bq.push_back(b);
      if (!we) begin
        r.cyc = t + 2 + i; r.port = port; r.data = d0 + DW'(i);
        rq.push_back(r);
      end
    end
  endtask

  // Monitor: compare every grant, SRAM beat and read response against the queues
  always @(negedge clk) begin
    grant_t g;
    beat_t  b;
    rsp_t   r;
    if (bus.req_ready != '0) begin
      if (gq.size() == 0) check("unexpected_grant", 64'(bus.req_ready), 64'(0));
      else begin
        g = gq.pop_front();
        check("grant_onehot", 64'(bus.req_ready), 64'(1) << g.port);
        check("grant_cyc", 64'(cyc), 64'(g.cyc));
      end
    end
    if (bus.mem_cs) begin
      if (bq.size() == 0) check("unexpected_beat", 64'(bus.mem_addr), 64'(0));
      else begin
        b = bq.pop_front();
        check("beat_cyc", 64'(cyc), 64'(b.cyc));
        check("beat_addr", 64'(bus.mem_addr), 64'(b.addr));
        check("beat_we", 64'(bus.mem_we), 64'(b.we));
        check("beat_wdata", 64'(bus.mem_wdata), 64'(b.wdata));
        check("beat_wbeat", 64'(bus.wbeat), b.we ? (64'(1) << b.port) : 64'(0));
        check("beat_busy", 64'(bus.busy), 64'(1));
        check("beat_owner", 64'(bus.owner), 64'(b.port));
      end
    end
    if (bus.rsp_valid != '0) begin
      if (rq.size() == 0) check("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
      else begin
        r = rq.pop_front();
        check("rsp_cyc", 64'(cyc), 64'(r.cyc));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(1) << r.port);
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(r.data));
      end
    end
  end

  initial begin
    int t;
    int t2;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wdata     = '0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = pat(AW'(i));

    // Reset with all requests asserted: everything must stay quiet
    rst = 1'b1;
    bus.req_valid = '1;
    goto(3);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_mem_cs", 64'(bus.mem_cs), 64'(0));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_owner", 64'(bus.owner), 64'(0));
    next_cyc();
    rst = 1'b0;
    bus.req_valid = '0;
    next_cyc();

    // Port 2 read 0x0010 len 3
    next_cyc();
    t = cyc;
    set_cmd(2, 1'b0, 16'h0010, 4'd3);
    exp_burst(t, 2, 1'b0, 16'h0010, 3, pat(16'h0010));
    next_cyc();
    bus.req_valid = '0;
    goto(t + 8);

    // Fresh reset, then all four ports contending with len 0
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    next_cyc();
    t = cyc;
    for (int p = 0; p < 4; p++) set_cmd(p, 1'b0, 16'h0020 + AW'(p), 4'd0);
    for (int j = 0; j < 5; j++)
      exp_burst(t + 2*j, j % 4, 1'b0, 16'h0020 + AW'(j % 4), 0, pat(16'h0020 + AW'(j % 4)));
    goto(t + 9);
    bus.req_valid = '0;
    goto(t + 13);

    // Port 1 write across the address wrap, then read it back
    next_cyc();
    t = cyc;
    set_cmd(1, 1'b1, 16'hFFFE, 4'd2);
    exp_burst(t, 1, 1'b1, 16'hFFFE, 2, 32'hA);
    next_cyc();
    bus.req_valid = '0;
    bus.wdata[1*DW +: DW] = 32'hA;
    next_cyc();
    bus.wdata[1*DW +: DW] = 32'hB;
    next_cyc();
    bus.wdata[1*DW +: DW] = 32'hC;
    next_cyc();
    bus.wdata = '0;
    t2 = cyc;
    set_cmd(1, 1'b0, 16'hFFFE, 4'd2);
    exp_burst(t2, 1, 1'b0, 16'hFFFE, 2, 32'hA);
    next_cyc();
    bus.req_valid = '0;
    goto(t2 + 6);

    // Port 0 read len 0 while port 3 waits: response overlaps port 3 grant
    next_cyc();
    t = cyc;
    set_cmd(0, 1'b0, 16'h0040, 4'd0);
    exp_burst(t, 0, 1'b0, 16'h0040, 0, pat(16'h0040));
    next_cyc();
    bus.req_valid[0] = 1'b0;
    set_cmd(3, 1'b0, 16'h0030, 4'd0);
    exp_burst(t + 2, 3, 1'b0, 16'h0030, 0, pat(16'h0030));
    next_cyc();
    next_cyc();
    bus.req_valid = '0;
    goto(t + 6);

    // Reset on the 2nd beat of a len 7 read aborts it; pointer returns to 0
    next_cyc();
    t = cyc;
    set_cmd(0, 1'b0, 16'h0050, 4'd7);
    begin
      grant_t g;
      beat_t  b;
      g.cyc = t; g.port = 0;
      gq.push_back(g);
      b.cyc = t + 1; b.port = 0; b.we = 1'b0; b.addr = 16'h0050; b.wdata = '0;
      bq.push_back(b);
    end
    next_cyc();
    bus.req_valid = '0;
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_cs", 64'(bus.mem_cs), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("abort_owner", 64'(bus.owner), 64'(0));
    next_cyc();
    t = cyc;
    set_cmd(0, 1'b0, 16'h0060, 4'd0);
    set_cmd(3, 1'b0, 16'h0070, 4'd1);
    exp_burst(t, 0, 1'b0, 16'h0060, 0, pat(16'h0060));
    exp_burst(t + 2, 3, 1'b0, 16'h0070, 1, pat(16'h0070));
    next_cyc();
    bus.req_valid[0] = 1'b0;
    goto(t + 3);
    bus.req_valid = '0;
    goto(t + 8);

    // Port 0 alone for three bursts of len 1
    next_cyc();
    t = cyc;
    set_cmd(0, 1'b0, 16'h0080, 4'd1);
    for (int j = 0; j < 3; j++) exp_burst(t + 3*j, 0, 1'b0, 16'h0080, 1, pat(16'h0080));
    goto(t + 7);
    bus.req_valid = '0;
    goto(t + 11);

    // Pointer now sits at 1: port 1 beats port 0
    next_cyc();
    t = cyc;
    set_cmd(0, 1'b0, 16'h0090, 4'd0);
    set_cmd(1, 1'b0, 16'h0091, 4'd0);
    exp_burst(t, 1, 1'b0, 16'h0091, 0, pat(16'h0091));
    exp_burst(t + 2, 0, 1'b0, 16'h0090, 0, pat(16'h0090));
    next_cyc();
    bus.req_valid[1] = 1'b0;
    goto(t + 3);
    bus.req_valid = '0;
    goto(t + 8);

    @(negedge clk);
    check("grants_outstanding", 64'(gq.size()), 64'(0));
    check("beats_outstanding", 64'(bq.size()), 64'(0));
    check("rsps_outstanding", 64'(rq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
